// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage load/store unit: flag bit
// positions, FSM states, access sizes and byte-enable base patterns.
package mem_pkg;

  localparam int LB_BIT  = 0;
  localparam int LH_BIT  = 1;
  localparam int LW_BIT  = 2;
  localparam int LBU_BIT = 3;
  localparam int LHU_BIT = 4;

  localparam int SB_BIT = 0;
  localparam int SH_BIT = 1;
  localparam int SW_BIT = 2;

  localparam logic [4:0] NO_LOAD  = 5'b00000;
  localparam logic [2:0] NO_STORE = 3'b000;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    mem_size_t size;
    logic      is_unsigned;
  } mem_op_t;

  // Loads win over stores; inside a flag field the lowest set bit wins.
  function automatic mem_op_t decode_op(input logic [4:0] load_flag,
                                        input logic [2:0] store_flag);
    mem_op_t op;
    op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_WORD, is_unsigned: 1'b0};
    if (load_flag != NO_LOAD) begin
      op.is_load = 1'b1;
      if (load_flag[LB_BIT]) begin
        op.size = SZ_BYTE;
      end else if (load_flag[LH_BIT]) begin
        op.size = SZ_HALF;
      end else if (load_flag[LW_BIT]) begin
        op.size = SZ_WORD;
      end else if (load_flag[LBU_BIT]) begin
        op.size        = SZ_BYTE;
        op.is_unsigned = 1'b1;
      end else begin
        op.size        = SZ_HALF;
        op.is_unsigned = 1'b1;
      end
    end else if (store_flag != NO_STORE) begin
      op.is_store = 1'b1;
      if (store_flag[SB_BIT]) begin
        op.size = SZ_BYTE;
      end else if (store_flag[SH_BIT]) begin
        op.size = SZ_HALF;
      end else begin
        op.size = SZ_WORD;
      end
    end
    return op;
  endfunction

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
    logic bad;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane formatting: store data/byte enables from offset and size, and
// load data extraction with sign or zero extension.
module mem_lane_fmt
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      offset,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{offset, 3'b000} +: 8];
  assign half_sel = rdata[{offset[1], 4'b0000} +: 16];

  always_comb begin
    be    = BE_WORD;
    wdata = store_data;
    case (size)
      SZ_BYTE: begin
        be    = BE_BYTE << offset;
        wdata = {(XLEN/8){store_data[7:0]}};
      end
      SZ_HALF: begin
        be    = BE_HALF << {offset[1], 1'b0};
        wdata = {(XLEN/16){store_data[15:0]}};
      end
      default: begin
        be    = BE_WORD;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    load_data = rdata;
    case (size)
      SZ_BYTE: load_data = {{(XLEN-8){byte_sel[7] & ~is_unsigned}}, byte_sel};
      SZ_HALF: load_data = {{(XLEN-16){half_sel[15] & ~is_unsigned}}, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage load/store unit with a single-outstanding req/gnt/rvalid data bus.
// Build option MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of masking.
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int XREG_ADDRWIDTH = 5,
  parameter int BUS_TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XLEN-1:0]           rd_in,
  input  logic                      rd_en_in,
  input  logic [XREG_ADDRWIDTH-1:0] rd_addr_in,
  input  logic [4:0]                load_flag_in,
  input  logic [2:0]                store_flag_in,
  input  logic [XLEN-1:0]           store_data_in,
  output logic                      mem_stall_o,
  output logic                      dbus_req_o,
  output logic                      dbus_we_o,
  output logic [XLEN-1:0]           dbus_addr_o,
  output logic [3:0]                dbus_be_o,
  output logic [XLEN-1:0]           dbus_wdata_o,
  input  logic                      dbus_gnt_i,
  input  logic                      dbus_rvalid_i,
  input  logic [XLEN-1:0]           dbus_rdata_i,
  input  logic                      dbus_err_i,
  output logic [XLEN-1:0]           wb_data_o,
  output logic                      wb_en_o,
  output logic [XREG_ADDRWIDTH-1:0] wb_addr_o,
  output logic                      fault_o,
  output logic [XLEN-1:0]           fault_addr_o
);

  localparam logic [7:0] TMO_LIMIT = 8'(BUS_TIMEOUT);

  // Bus handshake: a request is held (req and all attributes stable) until the
  // cycle gnt is high; load data then arrives later on a cycle with rvalid high.
  mem_state_t      state, state_n;
  logic [7:0]      tmo_cnt;
  mem_op_t         op;
  logic            op_valid;
  logic            misalign;
  logic            timeout;
  logic            in_req;
  logic            fault_evt;
  logic            wb_load;
  logic [3:0]      lane_be;
  logic [XLEN-1:0] lane_wdata;
  logic [XLEN-1:0] load_data;

  assign op       = decode_op(load_flag_in, store_flag_in);
  assign op_valid = op.is_load | op.is_store;
  assign timeout  = (tmo_cnt == TMO_LIMIT);
  assign in_req   = (state == REQ);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = op_valid & is_misaligned(op.size, rd_in[1:0]);
`else
  assign misalign = 1'b0;
`endif

  mem_lane_fmt #(.XLEN(XLEN)) u_lane_fmt (
    .offset      (rd_in[1:0]),
    .size        (op.size),
    .is_unsigned (op.is_unsigned),
    .store_data  (store_data_in),
    .rdata       (dbus_rdata_i),
    .be          (lane_be),
    .wdata       (lane_wdata),
    .load_data   (load_data)
  );

  // Bus attributes decode from state so they stay zero outside REQ.
  assign dbus_req_o   = in_req;
  assign dbus_we_o    = in_req & op.is_store;
  assign dbus_addr_o  = in_req ? {rd_in[XLEN-1:2], 2'b00} : '0;
  assign dbus_be_o    = in_req ? lane_be : 4'b0000;
  assign dbus_wdata_o = (in_req & op.is_store) ? lane_wdata : '0;

  always_comb begin
    state_n     = state;
    mem_stall_o = 1'b0;
    fault_evt   = 1'b0;
    wb_load     = 1'b0;
    case (state)
      IDLE: begin
        if (op_valid) begin
          mem_stall_o = 1'b1;
          fault_evt   = misalign;
          state_n     = misalign ? DONE : REQ;
        end
      end
      REQ: begin
        mem_stall_o = 1'b1;
        if (dbus_gnt_i) begin
          if (op.is_store) begin
            fault_evt = dbus_err_i;
            state_n   = DONE;
          end else begin
            state_n = RSP;
          end
        end else if (timeout) begin
          fault_evt = 1'b1;
          state_n   = DONE;
        end
      end
      RSP: begin
        mem_stall_o = 1'b1;
        if (dbus_rvalid_i) begin
          fault_evt = dbus_err_i;
          wb_load   = ~dbus_err_i;
          state_n   = DONE;
        end else if (timeout) begin
          fault_evt = 1'b1;
          state_n   = DONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= 8'd0;
      wb_data_o    <= '0;
      wb_en_o      <= 1'b0;
      wb_addr_o    <= '0;
      fault_o      <= 1'b0;
      fault_addr_o <= '0;
    end else begin
      state   <= state_n;
      fault_o <= fault_evt;
      if (fault_evt) begin
        fault_addr_o <= rd_in;
      end
      if (state == IDLE) begin
        tmo_cnt <= 8'd0;
      end else if (state == REQ || state == RSP) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      // Non-memory ops flow straight through; memory ops only write back on a clean response.
      if (state == IDLE && !op_valid) begin
        wb_data_o <= rd_in;
        wb_en_o   <= rd_en_in;
        wb_addr_o <= rd_addr_in;
      end else if (wb_load) begin
        wb_data_o <= load_data;
        wb_en_o   <= rd_en_in;
        wb_addr_o <= rd_addr_in;
      end else begin
        wb_en_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, bus errors,
// timeout, mid-access reset and the misaligned-word case.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rd_in;
  logic        rd_en_in;
  logic [4:0]  rd_addr_in;
  logic [4:0]  load_flag_in;
  logic [2:0]  store_flag_in;
  logic [31:0] store_data_in;
  logic        mem_stall_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
  logic        dbus_err_i;
  logic [31:0] wb_data_o;
  logic        wb_en_o;
  logic [4:0]  wb_addr_o;
  logic        fault_o;
  logic [31:0] fault_addr_o;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk           (clk),
    .rst           (rst),
    .rd_in         (rd_in),
    .rd_en_in      (rd_en_in),
    .rd_addr_in    (rd_addr_in),
    .load_flag_in  (load_flag_in),
    .store_flag_in (store_flag_in),
    .store_data_in (store_data_in),
    .mem_stall_o   (mem_stall_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i),
    .dbus_err_i    (dbus_err_i),
    .wb_data_o     (wb_data_o),
    .wb_en_o       (wb_en_o),
    .wb_addr_o     (wb_addr_o),
    .fault_o       (fault_o),
    .fault_addr_o  (fault_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_in         = 32'h0;
    rd_en_in      = 1'b0;
    rd_addr_in    = 5'd0;
    load_flag_in  = 5'b0;
    store_flag_in = 3'b0;
    store_data_in = 32'h0;
  endtask

  // Drives one load from IDLE through DONE with gnt on the first REQ cycle.
  task automatic run_load(input string tag, input logic [31:0] addr, input logic [4:0] lf,
                          input logic [2:0] sf, input logic [31:0] rdata, input logic err,
                          input logic [3:0] exp_be, input logic [31:0] exp_wb);
    rd_in = addr; load_flag_in = lf; store_flag_in = sf; store_data_in = 32'h5555_AAAA;
    rd_en_in = 1'b1; rd_addr_in = 5'd9;
    #1;
    check({tag, "_stall_idle"}, 32'(mem_stall_o), 32'd1);
    check({tag, "_noreq_idle"}, 32'(dbus_req_o), 32'd0);
    tick();
    check({tag, "_req"}, 32'(dbus_req_o), 32'd1);
    check({tag, "_we"}, 32'(dbus_we_o), 32'd0);
    check({tag, "_addr"}, dbus_addr_o, addr & 32'hFFFF_FFFC);
    check({tag, "_be"}, 32'(dbus_be_o), 32'(exp_be));
    check({tag, "_stall_req"}, 32'(mem_stall_o), 32'd1);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    check({tag, "_req_rsp"}, 32'(dbus_req_o), 32'd0);
    check({tag, "_stall_rsp"}, 32'(mem_stall_o), 32'd1);
    dbus_rvalid_i = 1'b1; dbus_rdata_i = rdata; dbus_err_i = err;
    tick();
    dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0; dbus_err_i = 1'b0;
    check({tag, "_stall_done"}, 32'(mem_stall_o), 32'd0);
    check({tag, "_wb_en"}, 32'(wb_en_o), err ? 32'd0 : 32'd1);
    check({tag, "_fault"}, 32'(fault_o), 32'(err));
    if (err) check({tag, "_fault_addr"}, fault_addr_o, addr);
    else begin
      check({tag, "_wb_data"}, wb_data_o, exp_wb);
      check({tag, "_wb_addr"}, 32'(wb_addr_o), 32'd9);
    end
    clear_inputs();
    tick();
    check({tag, "_wb_en_after"}, 32'(wb_en_o), 32'd0);
    check({tag, "_fault_after"}, 32'(fault_o), 32'd0);
  endtask

  // Drives one store, holding gnt low for gnt_wait REQ cycles first.
  task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] sf,
                           input logic [31:0] data, input int gnt_wait, input logic err,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    rd_in = addr; store_flag_in = sf; store_data_in = data; rd_en_in = 1'b1; rd_addr_in = 5'd3;
    #1;
    check({tag, "_stall_idle"}, 32'(mem_stall_o), 32'd1);
    tick();
    for (int i = 0; i < gnt_wait; i++) begin
      check({tag, "_wait_req"}, 32'(dbus_req_o), 32'd1);
      check({tag, "_wait_addr"}, dbus_addr_o, addr & 32'hFFFF_FFFC);
      check({tag, "_wait_wdata"}, dbus_wdata_o, exp_wdata);
      check({tag, "_wait_stall"}, 32'(mem_stall_o), 32'd1);
      tick();
    end
    check({tag, "_req"}, 32'(dbus_req_o), 32'd1);
    check({tag, "_we"}, 32'(dbus_we_o), 32'd1);
    check({tag, "_addr"}, dbus_addr_o, addr & 32'hFFFF_FFFC);
    check({tag, "_be"}, 32'(dbus_be_o), 32'(exp_be));
    check({tag, "_wdata"}, dbus_wdata_o, exp_wdata);
    check({tag, "_stall_req"}, 32'(mem_stall_o), 32'd1);
    dbus_gnt_i = 1'b1; dbus_err_i = err;
    tick();
    dbus_gnt_i = 1'b0; dbus_err_i = 1'b0;
    check({tag, "_stall_done"}, 32'(mem_stall_o), 32'd0);
    check({tag, "_req_done"}, 32'(dbus_req_o), 32'd0);
    check({tag, "_no_wb"}, 32'(wb_en_o), 32'd0);
    check({tag, "_fault"}, 32'(fault_o), 32'(err));
    if (err) check({tag, "_fault_addr"}, fault_addr_o, addr);
    clear_inputs();
    tick();
    check({tag, "_fault_after"}, 32'(fault_o), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0; dbus_err_i = 1'b0;
    clear_inputs();
    tick();
    tick();
    check("rst_wb_en", 32'(wb_en_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'h0);
    check("rst_fault", 32'(fault_o), 32'd0);
    check("rst_fault_addr", fault_addr_o, 32'h0);
    check("rst_req", 32'(dbus_req_o), 32'd0);
    check("rst_stall", 32'(mem_stall_o), 32'd0);
    rst = 1'b0;
    tick();

    // Non-memory op passes through in one cycle.
    rd_in = 32'h0000_1234; rd_en_in = 1'b1; rd_addr_in = 5'd5;
    #1;
    check("pass_stall", 32'(mem_stall_o), 32'd0);
    tick();
    check("pass_wb_en", 32'(wb_en_o), 32'd1);
    check("pass_wb_data", wb_data_o, 32'h0000_1234);
    check("pass_wb_addr", 32'(wb_addr_o), 32'd5);
    check("pass_stall2", 32'(mem_stall_o), 32'd0);
    clear_inputs();
    tick();
    check("pass_wb_en_clr", 32'(wb_en_o), 32'd0);

    run_load("lb", 32'h0000_1003, 5'b00001, 3'b000, 32'h80FF_FFFF, 1'b0, 4'b1000, 32'hFFFF_FF80);
    run_load("lhu", 32'h0000_2002, 5'b10000, 3'b000, 32'hBEEF_1234, 1'b0, 4'b1100, 32'h0000_BEEF);
    run_load("lh", 32'h0000_2000, 5'b00010, 3'b000, 32'h0000_8001, 1'b0, 4'b0011, 32'hFFFF_8001);
    run_load("lbu", 32'h0000_1001, 5'b01000, 3'b000, 32'h0000_A500, 1'b0, 4'b0010, 32'h0000_00A5);
    run_load("lw", 32'h0000_3000, 5'b00100, 3'b000, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF);
    run_load("prio", 32'h0000_2002, 5'b01010, 3'b100, 32'h8765_0000, 1'b0, 4'b1100, 32'hFFFF_8765);
    run_load("lw_err", 32'h0000_3004, 5'b00100, 3'b000, 32'h1111_2222, 1'b1, 4'b1111, 32'h0);

    run_store("sh", 32'h0000_2002, 3'b010, 32'h0000_ABCD, 0, 1'b0, 4'b1100, 32'hABCD_ABCD);
    run_store("sb", 32'h0000_4001, 3'b001, 32'h1234_5678, 0, 1'b0, 4'b0010, 32'h7878_7878);
    run_store("sw_wait", 32'h0000_5000, 3'b100, 32'hCAFE_F00D, 3, 1'b0, 4'b1111, 32'hCAFE_F00D);
    run_store("sb_err", 32'h0000_4003, 3'b011, 32'h0000_00EE, 1, 1'b1, 4'b1000, 32'hEEEE_EEEE);

    // Load whose response never comes: 255 RSP cycles then a fault.
    rd_in = 32'h0000_6004; load_flag_in = 5'b00100; rd_en_in = 1'b1; rd_addr_in = 5'd4;
    tick();
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    n = 0;
    while (!fault_o && n < 400) begin
      tick();
      n++;
    end
    check("tmo_fault_seen", 32'(fault_o), 32'd1);
    check("tmo_cycles", 32'(n), 32'd255);
    check("tmo_fault_addr", fault_addr_o, 32'h0000_6004);
    check("tmo_no_wb", 32'(wb_en_o), 32'd0);
    check("tmo_stall_done", 32'(mem_stall_o), 32'd0);
    clear_inputs();
    tick();
    check("tmo_pulse_end", 32'(fault_o), 32'd0);

    // Reset while waiting in RSP, then a stale response.
    rd_in = 32'h0000_7000; load_flag_in = 5'b00100; rd_en_in = 1'b1; rd_addr_in = 5'd6;
    tick();
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    check("rstmid_in_rsp", 32'(mem_stall_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1357_9BDF;
    #1;
    check("rstmid_stall", 32'(mem_stall_o), 32'd0);
    check("rstmid_fault_addr", fault_addr_o, 32'h0);
    tick();
    check("stale_wb_en", 32'(wb_en_o), 32'd0);
    check("stale_wb_data", wb_data_o, 32'h0);
    check("stale_fault", 32'(fault_o), 32'd0);
    check("stale_req", 32'(dbus_req_o), 32'd0);
    dbus_rvalid_i = 1'b0; dbus_rdata_i = 32'h0;
    tick();

`ifdef MEM_MISALIGN_TRAP_EN
    rd_in = 32'h0000_3001; load_flag_in = 5'b00100; rd_en_in = 1'b1; rd_addr_in = 5'd2;
    #1;
    check("mis_stall_idle", 32'(mem_stall_o), 32'd1);
    check("mis_noreq_idle", 32'(dbus_req_o), 32'd0);
    tick();
    check("mis_noreq_done", 32'(dbus_req_o), 32'd0);
    check("mis_fault", 32'(fault_o), 32'd1);
    check("mis_fault_addr", fault_addr_o, 32'h0000_3001);
    check("mis_stall_done", 32'(mem_stall_o), 32'd0);
    check("mis_no_wb", 32'(wb_en_o), 32'd0);
    clear_inputs();
    tick();
`else
    run_load("lw_mis", 32'h0000_3001, 5'b00100, 3'b000, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0BAD_F00D);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
